// File: rtl/alu181_pipe.sv
// W-bit clocked successor of the SN74LS181 ALU with a STAGES-deep valid/ready pipeline.
// Optional accumulator operand source enabled by defining ALU181_ACC_EN.
module alu181_pipe #(
    parameter int W      = 8,
    parameter int STAGES = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [3:0]   s,
    input  logic         m,
    input  logic         cn_,
    input  logic         acc_sel,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] f,
    output logic         cn4_,
    output logic         g_,
    output logic         p_,
    output logic         aeqb,
    output logic         ovr
);

    typedef struct packed {
        logic [W-1:0] f;
        logic         cn4_n;
        logic         g_n;
        logic         p_n;
        logic         aeqb;
        logic         ovr;
    } res_t;

    localparam res_t RES_RST = '{f: {W{1'b0}}, cn4_n: 1'b1, g_n: 1'b1, p_n: 1'b1,
                                 aeqb: 1'b0, ovr: 1'b0};

    logic [W-1:0]      opa_s;
    logic [W-1:0]      x_s;
    logic [W-1:0]      y_s;
    logic [W:0]        sum_s;
    logic              cin_s;
    logic              gen_s;
    res_t              res_s;
    logic              advance_s;
    logic              accept_s;
    res_t              stg_r [STAGES];
    logic [STAGES-1:0] vld_r;

    assign advance_s = ~out_valid | out_ready;
    assign in_ready  = advance_s;
    assign accept_s  = in_valid & advance_s;

`ifdef ALU181_ACC_EN
    logic [W-1:0] acc_r;

    // Accumulator captures the result at accept so chained ops see it without a pipeline hazard
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_r <= {W{1'b0}};
        end else if (accept_s) begin
            acc_r <= res_s.f;
        end
    end

    assign opa_s = acc_sel ? acc_r : a;
`else
    logic unused_acc_sel_s;
    assign unused_acc_sel_s = acc_sel;
    assign opa_s            = a;
`endif

    // '181 function: per-bit X/Y terms, then sum (arithmetic) or XNOR (logic)
    always_comb begin
        x_s   = opa_s | (b & {W{s[0]}}) | (~b & {W{s[1]}});
        y_s   = (opa_s & ~b & {W{s[2]}}) | (opa_s & b & {W{s[3]}});
        cin_s = ~cn_;
        sum_s = {1'b0, x_s} + {1'b0, y_s} + {{W{1'b0}}, cin_s};
        gen_s = 1'b0;
        for (int i = 0; i < W; i++) begin
            gen_s = (x_s[i] & y_s[i]) | ((x_s[i] | y_s[i]) & gen_s);
        end
        res_s = RES_RST;
        if (m) begin
            res_s.f    = ~(x_s ^ y_s);
            res_s.aeqb = &(~(x_s ^ y_s));
        end else begin
            res_s.f     = sum_s[W-1:0];
            res_s.cn4_n = ~sum_s[W];
            res_s.g_n   = ~gen_s;
            res_s.p_n   = ~&x_s;
            res_s.aeqb  = &sum_s[W-1:0];
            // carry into the MSB recovered from the MSB sum bit
            res_s.ovr   = (sum_s[W-1] ^ x_s[W-1] ^ y_s[W-1]) ^ sum_s[W];
        end
    end

    // Pipeline: valid bits always shift on advance; data only moves with a valid op,
    // so a bubble leaves the previous result parked on the outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                vld_r[i] <= 1'b0;
                stg_r[i] <= RES_RST;
            end
        end else if (advance_s) begin
            vld_r[0] <= accept_s;
            if (accept_s) begin
                stg_r[0] <= res_s;
            end
            for (int i = 1; i < STAGES; i++) begin
                vld_r[i] <= vld_r[i-1];
                if (vld_r[i-1]) begin
                    stg_r[i] <= stg_r[i-1];
                end
            end
        end
    end

    assign out_valid = vld_r[STAGES-1];
    assign f         = stg_r[STAGES-1].f;
    assign cn4_      = stg_r[STAGES-1].cn4_n;
    assign g_        = stg_r[STAGES-1].g_n;
    assign p_        = stg_r[STAGES-1].p_n;
    assign aeqb      = stg_r[STAGES-1].aeqb;
    assign ovr       = stg_r[STAGES-1].ovr;

endmodule

// File: tb/tb_alu181_pipe.sv
// Scoreboard bench for alu181_pipe: STAGES=1 instance for function vectors,
// STAGES=3 instance for streaming, back-pressure and mid-stream reset.
module tb_alu181_pipe;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       sel = 1'b0;
    logic [7:0] a = 8'h00;
    logic [7:0] b = 8'h00;
    logic [3:0] s = 4'h0;
    logic       m = 1'b0;
    logic       cn_ = 1'b1;
    logic       acc_sel = 1'b0;
    logic       out_ready = 1'b1;

    logic       in_valid1, in_valid3, in_ready1, in_ready3, out_valid1, out_valid3;
    logic [7:0] f1, f3;
    logic       cn4_1, g_1, p_1, aeqb1, ovr1;
    logic       cn4_3, g_3, p_3, aeqb3, ovr3;

    typedef struct {
        logic [12:0] v;
        int          issue;
        int          lat;
    } exp_t;

    exp_t q1[$];
    exp_t q3[$];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   stall_from = -1;
    int   stall_to = -1;
    logic ordy_default = 1'b1;

    assign in_valid1 = in_valid & ~sel;
    assign in_valid3 = in_valid & sel;

    alu181_pipe #(.W(8), .STAGES(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a), .b(b), .s(s), .m(m), .cn_(cn_), .acc_sel(acc_sel),
        .out_valid(out_valid1), .out_ready(out_ready), .f(f1), .cn4_(cn4_1),
        .g_(g_1), .p_(p_1), .aeqb(aeqb1), .ovr(ovr1)
    );

    alu181_pipe #(.W(8), .STAGES(3)) u_dut3 (
        .clk(clk), .rst(rst), .in_valid(in_valid3), .in_ready(in_ready3),
        .a(a), .b(b), .s(s), .m(m), .cn_(cn_), .acc_sel(acc_sel),
        .out_valid(out_valid3), .out_ready(out_ready), .f(f3), .cn4_(cn4_3),
        .g_(g_3), .p_(p_3), .aeqb(aeqb3), .ovr(ovr3)
    );

    always #5 clk = ~clk;

    function automatic logic [12:0] ex(input logic [7:0] ef, input logic c4, input logic g,
                                       input logic p, input logic eq, input logic ov);
        return {ef, c4, g, p, eq, ov};
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic pop(input int which, input logic [12:0] act);
        exp_t e;
        bit   have = 1'b0;
        if (which == 1 && q1.size() > 0) begin
            e = q1.pop_front();
            have = 1'b1;
        end else if (which == 3 && q3.size() > 0) begin
            e = q3.pop_front();
            have = 1'b1;
        end
        n_tests++;
        if (!have) begin
            n_fail++;
            $display("FAIL dut%0d unexpected output got={f,cn4_,g_,p_,aeqb,ovr}=%h", which, act);
        end else begin
            if (act !== e.v) begin
                n_fail++;
                $display("FAIL dut%0d result got={f,cn4_,g_,p_,aeqb,ovr}=%h exp=%h", which, act, e.v);
            end
            if (e.lat != 0) begin
                n_tests++;
                if (cyc - e.issue != e.lat) begin
                    n_fail++;
                    $display("FAIL dut%0d latency got=%0d exp=%0d", which, cyc - e.issue, e.lat);
                end
            end
        end
    endtask

    // Monitor: consumes results whenever a transfer will happen at the coming edge
    always @(negedge clk) begin
        #3;
        cyc++;
        if (!rst) begin
            if (out_valid1 && out_ready) pop(1, {f1, cn4_1, g_1, p_1, aeqb1, ovr1});
            if (out_valid3 && out_ready) pop(3, {f3, cn4_3, g_3, p_3, aeqb3, ovr3});
        end
    end

    task automatic set_ready();
        out_ready = (cyc >= stall_from && cyc < stall_to) ? 1'b0 : ordy_default;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            #1;
            set_ready();
            in_valid = 1'b0;
        end
    endtask

    task automatic send(input logic which3, input logic [7:0] ta, input logic [7:0] tb_,
                        input logic [3:0] ts, input logic tm, input logic tcn, input logic tacc,
                        input logic [12:0] ev, input int elat);
        bit done = 1'b0;
        for (int t = 0; t < 40 && !done; t++) begin
            @(negedge clk);
            #1;
            set_ready();
            sel = which3; a = ta; b = tb_; s = ts; m = tm; cn_ = tcn; acc_sel = tacc;
            in_valid = 1'b1;
            #1;
            if (which3 && !out_ready && out_valid3) chk("stall_in_ready", {15'b0, in_ready3}, 16'h0000);
            if (which3 ? in_ready3 : in_ready1) begin
                done = 1'b1;
                if (which3) q3.push_back('{v: ev, issue: cyc + 1, lat: elat});
                else        q1.push_back('{v: ev, issue: cyc + 1, lat: elat});
            end
        end
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout got=no_accept exp=accept");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out1", {3'b0, f1, cn4_1, g_1, p_1, aeqb1, ovr1}, {3'b0, ex(8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0)});
        chk("rst_valid", {14'b0, out_valid1, out_valid3}, 16'h0000);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", {14'b0, in_ready1, in_ready3}, 16'h0003);

        // arithmetic vectors, STAGES=1
        send(1'b0, 8'h03, 8'h05, 4'b1001, 1'b0, 1'b1, 1'b0, ex(8'h08, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0), 1);
        send(1'b0, 8'hFF, 8'h01, 4'b1001, 1'b0, 1'b1, 1'b0, ex(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 1);
        send(1'b0, 8'h7F, 8'h01, 4'b1001, 1'b0, 1'b1, 1'b0, ex(8'h80, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1), 1);
        send(1'b0, 8'h05, 8'h05, 4'b0110, 1'b0, 1'b0, 1'b0, ex(8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0), 1);
        send(1'b0, 8'h05, 8'h05, 4'b0110, 1'b0, 1'b1, 1'b0, ex(8'hFF, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0), 1);
        send(1'b0, 8'h12, 8'h34, 4'b0011, 1'b0, 1'b1, 1'b0, ex(8'hFF, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0), 1);
        send(1'b0, 8'h10, 8'h5A, 4'b1111, 1'b0, 1'b1, 1'b0, ex(8'h0F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 1);
        send(1'b0, 8'hC0, 8'h5A, 4'b1100, 1'b0, 1'b1, 1'b0, ex(8'h80, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0), 1);
        send(1'b0, 8'h40, 8'h00, 4'b1100, 1'b0, 1'b1, 1'b0, ex(8'h80, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1), 1);
        // logic vectors, cn_ must not matter
        send(1'b0, 8'h33, 8'h55, 4'b0000, 1'b1, 1'b0, 1'b0, ex(8'hCC, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0), 1);
        send(1'b0, 8'h33, 8'h55, 4'b0110, 1'b1, 1'b0, 1'b0, ex(8'h66, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0), 1);
        send(1'b0, 8'h33, 8'h55, 4'b1001, 1'b1, 1'b0, 1'b0, ex(8'h99, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0), 1);
        send(1'b0, 8'h33, 8'h55, 4'b1011, 1'b1, 1'b0, 1'b0, ex(8'h11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0), 1);
        send(1'b0, 8'h33, 8'h55, 4'b1110, 1'b1, 1'b0, 1'b0, ex(8'h77, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0), 1);
        send(1'b0, 8'h00, 8'h55, 4'b0000, 1'b1, 1'b1, 1'b0, ex(8'hFF, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0), 1);
        // accumulator chain
        send(1'b0, 8'h01, 8'h01, 4'b1001, 1'b0, 1'b1, 1'b0, ex(8'h02, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0), 1);
`ifdef ALU181_ACC_EN
        send(1'b0, 8'h01, 8'h01, 4'b1001, 1'b0, 1'b1, 1'b1, ex(8'h03, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0), 1);
        send(1'b0, 8'h01, 8'h01, 4'b1001, 1'b0, 1'b1, 1'b1, ex(8'h04, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0), 1);
`else
        send(1'b0, 8'h01, 8'h01, 4'b1001, 1'b0, 1'b1, 1'b1, ex(8'h02, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0), 1);
        send(1'b0, 8'h01, 8'h01, 4'b1001, 1'b0, 1'b1, 1'b1, ex(8'h02, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0), 1);
`endif
        idle(4);
        chk("q1_drained", q1.size(), 16'h0000);

        // STAGES=3 stream with a three-cycle downstream stall
        stall_from = cyc + 5;
        stall_to   = cyc + 8;
        send(1'b1, 8'h10, 8'h01, 4'b1001, 1'b0, 1'b1, 1'b0, ex(8'h11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0), 3);
        send(1'b1, 8'h20, 8'h02, 4'b1001, 1'b0, 1'b1, 1'b0, ex(8'h22, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0), 0);
        send(1'b1, 8'h7F, 8'h01, 4'b1001, 1'b0, 1'b1, 1'b0, ex(8'h80, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1), 0);
        send(1'b1, 8'hFF, 8'h01, 4'b1001, 1'b0, 1'b1, 1'b0, ex(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 0);
        send(1'b1, 8'h05, 8'h05, 4'b0110, 1'b0, 1'b1, 1'b0, ex(8'hFF, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0), 0);
        send(1'b1, 8'h33, 8'h55, 4'b1001, 1'b1, 1'b1, 1'b0, ex(8'h99, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0), 0);
        idle(12);
        chk("q3_drained", q3.size(), 16'h0000);

        // fill the pipe with downstream blocked, then reset mid-stream
        stall_from   = -1;
        stall_to     = -1;
        ordy_default = 1'b0;
        send(1'b1, 8'h01, 8'h02, 4'b1001, 1'b0, 1'b1, 1'b0, ex(8'h03, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0), 0);
        send(1'b1, 8'h03, 8'h04, 4'b1001, 1'b0, 1'b1, 1'b0, ex(8'h07, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0), 0);
        send(1'b1, 8'h7F, 8'h7F, 4'b1001, 1'b0, 1'b1, 1'b0, ex(8'hFE, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1), 0);
        idle(2);
        chk("pre_rst_valid", {15'b0, out_valid3}, 16'h0001);
        rst      = 1'b1;
        sel      = 1'b1;
        in_valid = 1'b1;
        #1;
        chk("rst_valid3", {15'b0, out_valid3}, 16'h0000);
        chk("rst_out3", {3'b0, f3, cn4_3, g_3, p_3, aeqb3, ovr3}, {3'b0, ex(8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0)});
        q3.delete();
        @(negedge clk);
        #1;
        chk("rst_ignore_in", {15'b0, out_valid3}, 16'h0000);
        in_valid = 1'b0;
        rst      = 1'b0;
        #1;
        chk("post_rst_ready", {15'b0, in_ready3}, 16'h0001);
        ordy_default = 1'b1;
        idle(5);
        chk("post_rst_idle", {15'b0, out_valid3}, 16'h0000);
        send(1'b1, 8'h0A, 8'h05, 4'b1001, 1'b0, 1'b0, 1'b0, ex(8'h10, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0), 3);
        idle(6);
        chk("q3_final", q3.size(), 16'h0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
